// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared constants and state encoding for the conv1d CFU sequencer,
// buffers and command decoder.
package conv1d_pkg;
    localparam int KERNEL_LENGTH = 8;
    localparam int PAD_LEFT      = 3;
    localparam int MAX_WIDTH     = 1024;
    localparam int MAX_CHANNELS  = 128;
    localparam int IN_ADDR_W     = 17;
    localparam int W_ADDR_W      = 10;
    localparam int OUT_ADDR_W    = 10;
    localparam int WIDTH_W       = 11;
    localparam int DEPTH_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        REPORT
    } state_e;
endpackage

// File: rtl/conv1d_tap_counter.sv
// conv1d_tap_counter: nested channel / filter tap / output position counters.
// Ports: clk, reset (sync, active-high); clear restarts at (0,0,0); adv steps
// one tap; width/depth are the latched config; fx/ox are the current filter
// tap and output position; last_tap/last_out flag the final tap of an output
// and of the whole schedule.
module conv1d_tap_counter
    import conv1d_pkg::*;
#(
    parameter int KERNEL_LENGTH = conv1d_pkg::KERNEL_LENGTH,
    parameter int FX_W          = $clog2(KERNEL_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  adv,
    input  logic [WIDTH_W-1:0]    width,
    input  logic [DEPTH_W-1:0]    depth,
    output logic [FX_W-1:0]       fx,
    output logic [OUT_ADDR_W-1:0] ox,
    output logic                  last_tap,
    output logic                  last_out
);
    logic [DEPTH_W-1:0]    ch_q;
    logic [FX_W-1:0]       fx_q;
    logic [OUT_ADDR_W-1:0] ox_q;
    logic                  last_ch;

    assign last_ch  = ch_q == depth - DEPTH_W'(1);
    assign last_tap = last_ch && fx_q == FX_W'(KERNEL_LENGTH - 1);
    assign last_out = last_tap && WIDTH_W'(ox_q) == width - WIDTH_W'(1);
    assign fx       = fx_q;
    assign ox       = ox_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ch_q <= '0;
            fx_q <= '0;
            ox_q <= '0;
        end else if (adv) begin
            ch_q <= last_ch ? '0 : ch_q + DEPTH_W'(1);
            fx_q <= last_tap ? '0 : fx_q + FX_W'(last_ch);
            ox_q <= last_tap ? ox_q + OUT_ADDR_W'(1) : ox_q;
        end
    end
endmodule

// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: walks every (out_x, filter_x, ch) tap one per clock, issuing
// input/weight buffer reads and MAC/accumulator/output-write strobes.
// Ports: clk, reset (sync, active-high); start/width/depth request a run;
// busy/done/err report status; in_rd_en/in_addr and w_rd_en/w_addr drive the
// buffers; mac_en/mac_zero/acc_clear drive the MAC one cycle after issue;
// out_we/out_addr write the finished output two cycles after its last tap.
module conv1d_sequencer #(
    parameter int KERNEL_LENGTH = conv1d_pkg::KERNEL_LENGTH,
    parameter int PAD_LEFT      = conv1d_pkg::PAD_LEFT,
    parameter int MAX_WIDTH     = conv1d_pkg::MAX_WIDTH,
    parameter int MAX_CHANNELS  = conv1d_pkg::MAX_CHANNELS,
    parameter int IN_ADDR_W     = conv1d_pkg::IN_ADDR_W,
    parameter int W_ADDR_W      = conv1d_pkg::W_ADDR_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [conv1d_pkg::WIDTH_W-1:0]    width,
    input  logic [conv1d_pkg::DEPTH_W-1:0]    depth,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic                              in_rd_en,
    output logic [IN_ADDR_W-1:0]              in_addr,
    output logic                              w_rd_en,
    output logic [W_ADDR_W-1:0]               w_addr,
    output logic                              mac_en,
    output logic                              mac_zero,
    output logic                              acc_clear,
    output logic                              out_we,
    output logic [conv1d_pkg::OUT_ADDR_W-1:0] out_addr
);
    import conv1d_pkg::*;

    localparam int FX_W  = $clog2(KERNEL_LENGTH);
    localparam int SUM_W = OUT_ADDR_W + 2;

    state_e                state_q, state_d;
    logic [WIDTH_W-1:0]    width_q;
    logic [DEPTH_W-1:0]    depth_q;
    logic                  err_q, drain_q, drain_d;
    // Two's-complement input pointer; wraps modulo 2^IN_ADDR_W, which is exact
    // for every valid tap because valid addresses always fit the buffer.
    logic [IN_ADDR_W-1:0]  in_base_q, in_ptr_q, in_next, pad_start;
    logic [W_ADDR_W-1:0]   w_cnt_q;
    logic [FX_W-1:0]       fx;
    logic [OUT_ADDR_W-1:0] ox, ox1_q, out_addr_q;
    logic [SUM_W-1:0]      tap_sum;
    logic                  last_tap, last_out, accept, cfg_bad, issue, tap_valid;
    logic                  mac_en_q, mac_zero_q, acc_clear_q, last1_q, out_we_q;

    conv1d_tap_counter #(.KERNEL_LENGTH(KERNEL_LENGTH), .FX_W(FX_W)) u_taps (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .adv      (issue),
        .width    (width_q),
        .depth    (depth_q),
        .fx       (fx),
        .ox       (ox),
        .last_tap (last_tap),
        .last_out (last_out)
    );

    assign accept    = state_q == IDLE && start;
    assign cfg_bad   = width == '0 || depth == '0 || width > WIDTH_W'(MAX_WIDTH)
                       || depth > DEPTH_W'(MAX_CHANNELS);
    assign issue     = state_q == RUN;
    assign pad_start = -(IN_ADDR_W'(PAD_LEFT) * IN_ADDR_W'(depth));
    assign in_next   = in_base_q + IN_ADDR_W'(depth_q);
    // in_x = out_x + filter_x - PAD_LEFT lies in [0, width) without going negative.
    assign tap_sum   = SUM_W'(ox) + SUM_W'(fx);
    assign tap_valid = tap_sum >= SUM_W'(PAD_LEFT) && tap_sum < SUM_W'(width_q) + SUM_W'(PAD_LEFT);

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        unique case (state_q)
            IDLE:    state_d = start ? (cfg_bad ? REPORT : RUN) : IDLE;
            RUN:     state_d = last_out ? DRAIN : RUN;
            DRAIN: begin
                drain_d = ~drain_q;
                state_d = drain_q ? REPORT : DRAIN;
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            drain_q     <= 1'b0;
            width_q     <= '0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            in_base_q   <= '0;
            in_ptr_q    <= '0;
            w_cnt_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_zero_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            last1_q     <= 1'b0;
            ox1_q       <= '0;
            out_we_q    <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            mac_en_q    <= issue;
            mac_zero_q  <= issue && !tap_valid;
            acc_clear_q <= issue && w_cnt_q == '0;
            last1_q     <= issue && last_tap;
            ox1_q       <= ox;
            out_we_q    <= last1_q;
            out_addr_q  <= ox1_q;
            if (accept) begin
                width_q   <= width;
                depth_q   <= depth;
                err_q     <= cfg_bad;
                in_base_q <= pad_start;
                in_ptr_q  <= pad_start;
                w_cnt_q   <= '0;
            end else if (issue) begin
                in_base_q <= last_tap ? in_next : in_base_q;
                in_ptr_q  <= last_tap ? in_next : in_ptr_q + IN_ADDR_W'(1);
                w_cnt_q   <= last_tap ? '0 : w_cnt_q + W_ADDR_W'(1);
            end
        end
    end

    assign busy      = state_q == RUN || state_q == DRAIN;
    assign done      = state_q == REPORT;
    assign err       = done && err_q;
    assign w_rd_en   = issue;
    assign w_addr    = issue ? w_cnt_q : '0;
    assign in_rd_en  = issue && tap_valid;
    assign in_addr   = in_rd_en ? in_ptr_q : '0;
    assign mac_en    = mac_en_q;
    assign mac_zero  = mac_zero_q;
    assign acc_clear = acc_clear_q;
    assign out_we    = out_we_q;
    assign out_addr  = out_addr_q;
endmodule

// File: tb/tb_conv1d_sequencer.sv
// tb_conv1d_sequencer: scoreboard bench; stimulus pushes expected events, a monitor pops and compares.
module tb_conv1d_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [10:0] width = '0;
    logic [7:0]  depth = '0;
    logic        busy, done, err, in_rd_en, w_rd_en, mac_en, mac_zero, acc_clear, out_we;
    logic [16:0] in_addr;
    logic [9:0]  w_addr, out_addr;

    typedef struct packed {logic rd; logic [16:0] ia; logic [9:0] wa;} iss_t;
    typedef struct packed {logic err; logic [31:0] cyc;} done_t;

    iss_t       q_iss[$];
    logic [1:0] q_mac[$];
    logic [9:0] q_out[$];
    done_t      q_done[$];
    int         total = 0, bad = 0, busy_cnt = 0;

    always #5 clk = ~clk;

    conv1d_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .width(width), .depth(depth),
        .busy(busy), .done(done), .err(err), .in_rd_en(in_rd_en), .in_addr(in_addr),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .mac_en(mac_en), .mac_zero(mac_zero),
        .acc_clear(acc_clear), .out_we(out_we), .out_addr(out_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference schedule; r >= 0 means reset lands during issue index r.
    task automatic push_run(input int w, input int d, input int r);
        int idx = 0;
        for (int ox = 0; ox < w; ox++)
            for (int fx = 0; fx < 8; fx++)
                for (int ch = 0; ch < d; ch++) begin
                    int   inx;
                    logic v;
                    inx = ox + fx - 3;
                    v   = inx >= 0 && inx < w;
                    if (r < 0 || idx <= r)
                        q_iss.push_back(iss_t'{v, v ? 17'(inx * d + ch) : 17'd0, 10'(fx * d + ch)});
                    if (r < 0 || idx < r)
                        q_mac.push_back({!v, fx == 0 && ch == 0});
                    if (fx == 7 && ch == d - 1 && (r < 0 || idx + 2 <= r))
                        q_out.push_back(10'(ox));
                    idx++;
                end
        if (r < 0) q_done.push_back(done_t'{1'b0, 32'(w * 8 * d + 2)});
    endtask

    task automatic go(input int w, input int d);
        @(negedge clk);
        width = 11'(w);
        depth = 8'(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic run(input int w, input int d);
        push_run(w, d, -1);
        go(w, d);
        wait_done(w * 8 * d + 20);
    endtask

    task automatic cfg_err(input int w, input int d);
        q_done.push_back(done_t'{1'b1, 32'd0});
        go(w, d);
        check("cfg_err_at_t1", {done, err, busy}, 3'b110);
    endtask

    always @(negedge clk) begin
        if (reset) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (w_rd_en === 1'b1) begin
            if (q_iss.size() == 0) check("issue_extra", 1, 0);
            else begin
                iss_t e;
                e = q_iss.pop_front();
                check("in_rd_en", in_rd_en, e.rd);
                check("in_addr", in_addr, e.ia);
                check("w_addr", w_addr, e.wa);
            end
        end else if (in_rd_en === 1'b1) check("in_rd_no_issue", 1, 0);
        if (mac_en === 1'b1) begin
            if (q_mac.size() == 0) check("mac_extra", 1, 0);
            else check("mac_zero_clear", {mac_zero, acc_clear}, q_mac.pop_front());
        end
        if (out_we === 1'b1) begin
            if (q_out.size() == 0) check("out_we_extra", 1, 0);
            else check("out_addr", out_addr, q_out.pop_front());
        end
        if (done === 1'b1) begin
            if (q_done.size() == 0) check("done_extra", 1, 0);
            else begin
                done_t e;
                e = q_done.pop_front();
                check("err", err, e.err);
                check("busy_cycles", busy_cnt, e.cyc);
                check("busy_low_at_done", busy, 0);
            end
            busy_cnt = 0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, in_rd_en, w_rd_en, mac_en, mac_zero, acc_clear,
                                out_we, in_addr, w_addr, out_addr}, 0);
        reset = 1'b0;
        run(1, 1);
        run(4, 2);
        cfg_err(4, 0);
        cfg_err(0, 2);
        cfg_err(1025, 1);
        cfg_err(2, 129);
        // start pulsed mid-run must not restart the schedule
        push_run(2, 3, -1);
        go(2, 3);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        // start in the done cycle is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run(3, 1);
        // reset during issue 20
        push_run(4, 2, 20);
        go(4, 2);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {busy, done, err, in_rd_en, w_rd_en, mac_en, mac_zero, acc_clear,
                                    out_we, in_addr, w_addr, out_addr}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("no_done_after_reset", done, 0);
        run(3, 1);
        run(1024, 1);
        run(2, 128);
        repeat (5) @(negedge clk);
        check("issues_left", q_iss.size(), 0);
        check("macs_left", q_mac.size(), 0);
        check("outs_left", q_out.size(), 0);
        check("dones_left", q_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv1d_sequencer.md
# conv1d_sequencer

Multi-cycle scheduler for the conv1d CFU datapath. On `start` it walks every (output position, kernel tap, input channel) triple one per clock, issuing read addresses to the input and kernel-weight buffers and control strobes to the MAC/accumulator. It replaces the single-cycle nested-loop compute command with a pipelined schedule and reports `busy`/`done` back to the CFU response logic.

## Interface
Parameters:
- `KERNEL_LENGTH`, default 8: taps per output.
- `PAD_LEFT`, default 3: left padding; first tap of `out_x` reads `in_x = out_x - PAD_LEFT`.
- `MAX_WIDTH`, default 1024: maximum input/output width.
- `MAX_CHANNELS`, default 128: maximum input depth.
- `IN_ADDR_W`, default 17: input-buffer address width.
- `W_ADDR_W`, default 10: weight-buffer address width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `width` in 11: output width = input width; sampled with `start`.
- `depth` in 8: input channels; sampled with `start`.
- `busy` out 1: schedule in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = config rejected, nothing executed.
- `in_rd_en` out 1: input-buffer read strobe.
- `in_addr` out `IN_ADDR_W`: input-buffer address.
- `w_rd_en` out 1: weight-buffer read strobe.
- `w_addr` out `W_ADDR_W`: weight-buffer address.
- `mac_en` out 1: read data valid; accumulate this cycle.
- `mac_zero` out 1: with `mac_en`, padding tap; product forced to 0.
- `acc_clear` out 1: with `mac_en`, first tap of an output; accumulator loads product instead of adding.
- `out_we` out 1: write accumulator + bias to output buffer.
- `out_addr` out 10: output-buffer address (`out_x`).

## Operation
- States: IDLE, RUN, DRAIN, REPORT.
- IDLE + `start`: latch `width`, `depth`. If `width`==0, `depth`==0, `width`>`MAX_WIDTH`, or `depth`>`MAX_CHANNELS`, go to REPORT with `err`=1. Otherwise go to RUN.
- RUN issues one tap per cycle, channel innermost, then filter_x, then out_x.
- `w_addr` = `filter_x*depth + ch`. Implemented as a counter 0..`KERNEL_LENGTH*depth`-1 that restarts at each out_x.
- `in_addr` = `in_x*depth + ch`. Implemented as a signed counter:
  - start value `-PAD_LEFT*depth`
  - +1 per tap
  - on out_x advance, next start = previous start + `depth`
  - no multiplier in the loop
- A tap is valid iff 0 ≤ `in_x` < `width`. Invalid taps still issue `w_rd_en`, hold `in_rd_en`=0, and produce `mac_zero`=1 one cycle later.
- After the final tap of the final out_x: DRAIN for 2 cycles, then REPORT (`done`=1 for 1 cycle), then IDLE.
- `start` in any state other than IDLE is ignored.
- Reset values: state IDLE; all outputs 0 (`busy`, `done`, `err`, strobes, addresses).
- Reset mid-run: the next cycle is IDLE; no further `out_we` or `done`.

## Timing
- Cycle t: `start` sampled. t+1: first RUN issue, `busy`=1.
- Buffer read latency is 1 cycle. `mac_en`/`mac_zero`/`acc_clear` are delayed 1 cycle from issue.
- `out_we`/`out_addr` fire 2 cycles after the last issue of each out_x: one cycle for read, one for accumulate.
- Writes for consecutive out_x never collide: at most one `out_we` per cycle.
- Total `busy` cycles = `width*KERNEL_LENGTH*depth + 2`. `done` fires the cycle after `busy` falls.
- Config error: `done`=`err`=1 at t+1, `busy` never asserts.
- `err` is 0 on successful `done`.
- Back-to-back: a `start` in the `done` cycle is ignored; `start` is accepted from the following cycle.

## Structure
- Package `conv1d_pkg` holds:
  - `KERNEL_LENGTH`, `PAD_LEFT`, `MAX_WIDTH`, `MAX_CHANNELS`
  - the state enum
  - the address-width localparams shared with the buffer and CFU-decoder blocks
- Sub-module `conv1d_tap_counter` holds the nested ch/filter_x/out_x counters and produces `last_ch`, `last_tap`, `last_out`.
- The top level holds the FSM, the address counters and the delay pipeline.

## Test plan
- width=1, depth=1: 8 issue cycles, `w_addr` 0..7. Only filter_x=3 has `in_rd_en`=1 (`in_addr`=0). `mac_zero` is 1 on the other 7 taps. One `out_we`, `out_addr`=0. `busy` lasts 10 cycles.
- width=4, depth=2: 64 issues; `acc_clear` every 16th `mac_en`.
  - out_x=0: first valid `in_addr`=0, issued at filter_x=3.
  - out_x=3: filter_x=7 gives `in_x`=7, outside width → `mac_zero`=1.
  - `out_we` at `out_addr` 0,1,2,3.
- Config errors: `depth`=0, `width`=0 and `width`=1025 each give `done`=`err`=1 one cycle after `start`, with no strobes.
- `start` pulsed during RUN: no restart, total cycle count unchanged.
- Reset asserted at issue 20 of width=4, depth=2: next cycle IDLE, all outputs 0, no `done`. A fresh `start` then runs to completion.
- width=1024, depth=128 (max): `in_addr` peaks at 131071, last `out_addr`=1023, `busy` lasts 1048578 cycles.
